// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Groups the instruction-field inputs, datapath control outputs and data
// memory handshake of the multicycle controller.
//   master : the controller (consumes EN/OPCODE/MM/STAT/MEM_RDY, drives controls)
//   slave  : the datapath / instruction register side
// Signals:
//   EN        stall control, 0 freezes the controller
//   OPCODE    instruction opcode field
//   MM        addressing-mode / condition-mask field
//   STAT      ALU status flags
//   MEM_RDY   data memory done
//   RF_WE, WB_SEL, RD_SEL, ALU_OP       register file / ALU controls
//   PC_SEL, BR_SEL, PC_WRITE, PC_RST    program counter controls
//   MEM_REQ, MEM_WE                     data memory request / write
//   HALTED, ERR, STATE                  status and debug
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if #(
  parameter int OP_W = 4,
  parameter int MM_W = 4
);
  logic            EN;
  logic [OP_W-1:0] OPCODE;
  logic [MM_W-1:0] MM;
  logic [MM_W-1:0] STAT;
  logic            MEM_RDY;

  logic            RF_WE;
  logic            WB_SEL;
  logic            RD_SEL;
  logic [1:0]      ALU_OP;
  logic            PC_SEL;
  logic            BR_SEL;
  logic            PC_WRITE;
  logic            PC_RST;
  logic            MEM_REQ;
  logic            MEM_WE;
  logic            HALTED;
  logic            ERR;
  logic [2:0]      STATE;

  modport master (
    input  EN, OPCODE, MM, STAT, MEM_RDY,
    output RF_WE, WB_SEL, RD_SEL, ALU_OP, PC_SEL, BR_SEL, PC_WRITE, PC_RST,
           MEM_REQ, MEM_WE, HALTED, ERR, STATE
  );

  modport slave (
    output EN, OPCODE, MM, STAT, MEM_RDY,
    input  RF_WE, WB_SEL, RD_SEL, ALU_OP, PC_SEL, BR_SEL, PC_WRITE, PC_RST,
           MEM_REQ, MEM_WE, HALTED, ERR, STATE
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multicycle CPU control FSM. Decodes the instruction opcode and sequences
// FETCH / DECODE / EXECUTE / MEM / WB per opcode, driving register-file, ALU,
// PC and data-memory controls. Supports per-opcode stage skipping, a
// load/store memory handshake with timeout, a sticky HALT state, illegal
// opcode trapping and a global stall enable.
// Ports:
//   CLK    rising-edge clock
//   RST_F  asynchronous active-low reset
//   bus    multicycle_ctrl_if.master (see interface file for signal list)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int OP_W        = 4,
  parameter int MM_W        = 4,
  parameter int IMM_MODE    = 8,
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                CLK,
  input logic                RST_F,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    ST_START0  = 3'd0,
    ST_START1  = 3'd1,
    ST_FETCH   = 3'd2,
    ST_DECODE  = 3'd3,
    ST_EXECUTE = 3'd4,
    ST_MEM     = 3'd5,
    ST_WB      = 3'd6,
    ST_HALT    = 3'd7
  } state_e;

  localparam logic [OP_W-1:0] OP_NOOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LOD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STR  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BRA  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BRR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ALU  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_HLT  = {OP_W{1'b1}};

  localparam logic [MM_W-1:0]  MM_IMM    = MM_W'(IMM_MODE);
  localparam logic [TMO_W:0]   TMO_LIMIT = (TMO_W+1)'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [MM_W-1:0]   mm_q, mm_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;

  logic              rf_we, wb_sel, rd_sel, pc_sel, br_sel, pc_write, pc_rst;
  logic              mem_req, mem_we, halted;
  logic [1:0]        alu_op;

  logic              in_legal;
  logic              q_imm;
  logic              br_hit;
  logic              br_taken;
  logic [TMO_W:0]    tmo_inc;
  logic              tmo_trip;

  // Opcode legality of the live instruction field, checked while in DECODE.
  always_comb begin
    unique case (bus.OPCODE)
      OP_NOOP, OP_LOD, OP_STR, OP_BRA, OP_BRR, OP_BNE, OP_ALU, OP_HLT:
        in_legal = 1'b1;
      default:
        in_legal = 1'b0;
    endcase
  end

  // Helpers on the latched instruction fields. The timeout counts the
  // current MEM cycle too, so the trap fires on the MEM_TIMEOUT-th stalled
  // cycle rather than one later.
  assign q_imm    = (mm_q == MM_IMM);
  assign br_hit   = |(mm_q & bus.STAT);
  assign br_taken = (op_q == OP_BNE) ? !br_hit : br_hit;
  assign tmo_inc  = {1'b0, tmo_q} + (TMO_W+1)'(1);
  assign tmo_trip = (MEM_TIMEOUT != 0) && (tmo_inc == TMO_LIMIT);

  // State, latched instruction fields, timeout counter and sticky error.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state_q <= ST_START0;
      op_q    <= '0;
      mm_q    <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mm_q    <= mm_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Next-state and output decode. All outputs depend only on present state,
  // latched fields and STAT, except RD_SEL in DECODE which previews the live
  // opcode so the immediate operand is selected one cycle early.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mm_d     = mm_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    rd_sel   = 1'b0;
    alu_op   = 2'b00;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_write = 1'b0;
    pc_rst   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;

    unique case (state_q)
      ST_START0: begin
        pc_rst  = 1'b1;
        state_d = ST_START1;
      end

      ST_START1: begin
        pc_rst  = 1'b1;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        pc_write = 1'b1;
        state_d  = ST_DECODE;
      end

      ST_DECODE: begin
        rd_sel = (bus.OPCODE == OP_ALU) && (bus.MM == MM_IMM);
        op_d   = bus.OPCODE;
        mm_d   = bus.MM;
        if (bus.OPCODE == OP_NOOP) begin
          state_d = ST_FETCH;
        end else if (bus.OPCODE == OP_HLT) begin
          state_d = ST_HALT;
        end else if (!in_legal) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end else begin
          state_d = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        if (op_q == OP_ALU) begin
          alu_op  = q_imm ? 2'b01 : 2'b00;
          rd_sel  = q_imm;
          state_d = ST_WB;
        end else if ((op_q == OP_LOD) || (op_q == OP_STR)) begin
          alu_op  = 2'b01;
          rd_sel  = 1'b1;
          tmo_d   = '0;
          state_d = ST_MEM;
        end else if ((op_q == OP_BRA) || (op_q == OP_BRR) || (op_q == OP_BNE)) begin
          alu_op   = 2'b10;
          pc_sel   = br_taken;
          pc_write = br_taken;
          br_sel   = br_taken && (op_q != OP_BRR);
          state_d  = ST_FETCH;
        end else begin
          // Only reachable if the latched opcode is corrupted; trap it.
          state_d = ST_HALT;
          err_d   = 1'b1;
        end
      end

      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OP_STR);
        alu_op  = 2'b01;
        rd_sel  = 1'b1;
        if (bus.MEM_RDY) begin
          state_d = (op_q == OP_LOD) ? ST_WB : ST_FETCH;
        end else if (tmo_trip) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end else if (!(&tmo_q)) begin
          tmo_d = tmo_inc[TMO_W-1:0];
        end
      end

      ST_WB: begin
        rf_we = 1'b1;
        if (op_q == OP_LOD) begin
          wb_sel = 1'b1;
          alu_op = 2'b01;
          rd_sel = 1'b1;
        end else begin
          alu_op = q_imm ? 2'b01 : 2'b00;
          rd_sel = q_imm;
        end
        state_d = ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ST_START0;
      end
    endcase

    // Stall: freeze all state and suppress every write/request strobe.
    if (!bus.EN) begin
      state_d  = state_q;
      op_d     = op_q;
      mm_d     = mm_q;
      tmo_d    = tmo_q;
      err_d    = err_q;
      rf_we    = 1'b0;
      pc_write = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
    end
  end

  assign bus.RF_WE    = rf_we;
  assign bus.WB_SEL   = wb_sel;
  assign bus.RD_SEL   = rd_sel;
  assign bus.ALU_OP   = alu_op;
  assign bus.PC_SEL   = pc_sel;
  assign bus.BR_SEL   = br_sel;
  assign bus.PC_WRITE = pc_write;
  assign bus.PC_RST   = pc_rst;
  assign bus.MEM_REQ  = mem_req;
  assign bus.MEM_WE   = mem_we;
  assign bus.HALTED   = halted;
  assign bus.ERR      = err_q;
  assign bus.STATE    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. Each cycle the expected output vector
// is queued as the inputs are driven and compared at the following falling
// edge.
// Output vector layout:
//   [15:13] STATE  [12] HALTED  [11] ERR  [10] PC_RST  [9] PC_WRITE
//   [8] PC_SEL  [7] BR_SEL  [6] RF_WE  [5] WB_SEL  [4] RD_SEL
//   [3:2] ALU_OP  [1] MEM_REQ  [0] MEM_WE
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [15:0] HAL = 16'h1000;
  localparam logic [15:0] ERB = 16'h0800;
  localparam logic [15:0] PCR = 16'h0400;
  localparam logic [15:0] PCW = 16'h0200;
  localparam logic [15:0] PCS = 16'h0100;
  localparam logic [15:0] BRS = 16'h0080;
  localparam logic [15:0] RFW = 16'h0040;
  localparam logic [15:0] WBS = 16'h0020;
  localparam logic [15:0] RDS = 16'h0010;
  localparam logic [15:0] A10 = 16'h0008;
  localparam logic [15:0] A01 = 16'h0004;
  localparam logic [15:0] MRQ = 16'h0002;
  localparam logic [15:0] MWE = 16'h0001;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_BAD  = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  typedef struct {
    logic [15:0] vec;
    string       tag;
  } exp_t;

  logic clk;
  logic rst_f;
  int   tests_run;
  int   tests_failed;
  exp_t sb_q[$];

  multicycle_ctrl_if #(.OP_W(4), .MM_W(4)) bus ();

  multicycle_ctrl #(
    .OP_W(4), .MM_W(4), .IMM_MODE(8), .TMO_W(4), .MEM_TIMEOUT(15)
  ) u_dut (
    .CLK   (clk),
    .RST_F (rst_f),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] st(input int s);
    logic [2:0] s3;
    s3 = 3'(s);
    return {s3, 13'b0};
  endfunction

  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] mm,
                               input logic [3:0] stat, input logic rdy,
                               input logic en);
    bus.OPCODE  = op;
    bus.MM      = mm;
    bus.STAT    = stat;
    bus.MEM_RDY = rdy;
    bus.EN      = en;
  endtask

  task automatic expectOut(input logic [15:0] vec, input string tag);
    exp_t e;
    e.vec = vec;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge.
  task automatic checkOutput();
    exp_t        e;
    logic [15:0] obs;
    @(negedge clk);
    obs = {bus.STATE, bus.HALTED, bus.ERR, bus.PC_RST, bus.PC_WRITE, bus.PC_SEL,
           bus.BR_SEL, bus.RF_WE, bus.WB_SEL, bus.RD_SEL, bus.ALU_OP,
           bus.MEM_REQ, bus.MEM_WE};
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty: observed %h required an expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.vec) else begin
        tests_failed++;
        $error("[TB] FAIL %s: observed %h required %h", e.tag, obs, e.vec);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runCycle(input logic [3:0] op, input logic [3:0] mm,
                          input logic [3:0] stat, input logic rdy, input logic en,
                          input logic [15:0] vec, input string tag);
    applyStimulus(op, mm, stat, rdy, en);
    expectOut(vec, tag);
    checkOutput();
  endtask

  // Release reset just after a rising edge and walk START0/START1.
  task automatic resetSequence(input logic [3:0] op, input logic [3:0] mm);
    rst_f = 1'b0;
    runCycle(op, mm, 4'd0, 1'b0, 1'b1, st(0) | PCR, "reset_hold");
    rst_f = 1'b1;
    runCycle(op, mm, 4'd0, 1'b0, 1'b1, st(0) | PCR, "start0");
    runCycle(op, mm, 4'd0, 1'b0, 1'b1, st(1) | PCR, "start1");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_f        = 1'b0;
    applyStimulus(OP_ALU, 4'd0, 4'd0, 1'b0, 1'b1);

    // Reset, then ALU register op: 0,1,2,3,4,6,2
    resetSequence(OP_ALU, 4'd0);
    runCycle(OP_ALU, 4'd0, 4'd0, 1'b0, 1'b1, st(2) | PCW, "alu_fetch");
    runCycle(OP_ALU, 4'd0, 4'd0, 1'b0, 1'b1, st(3), "alu_decode");
    runCycle(OP_ALU, 4'd0, 4'd0, 1'b0, 1'b1, st(4), "alu_exec");
    runCycle(OP_ALU, 4'd0, 4'd0, 1'b0, 1'b1, st(6) | RFW, "alu_wb");
    runCycle(OP_ALU, 4'd8, 4'd0, 1'b0, 1'b1, st(2) | PCW, "alui_fetch");

    // ALU immediate
    runCycle(OP_ALU, 4'd8, 4'd0, 1'b0, 1'b1, st(3) | RDS, "alui_decode");
    runCycle(OP_NOOP, 4'd0, 4'd0, 1'b0, 1'b1, st(4) | RDS | A01, "alui_exec");
    runCycle(OP_NOOP, 4'd0, 4'd0, 1'b0, 1'b1, st(6) | RFW | RDS | A01, "alui_wb");
    runCycle(OP_NOOP, 4'd0, 4'd0, 1'b0, 1'b1, st(2) | PCW, "noop_fetch");

    // NOOP returns straight to FETCH
    runCycle(OP_NOOP, 4'd0, 4'd0, 1'b0, 1'b1, st(3), "noop_decode");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(2) | PCW, "lod_fetch");

    // LOD with MEM_RDY low for 3 cycles
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(3), "lod_decode");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(4) | RDS | A01, "lod_exec");
    for (int i = 0; i < 3; i++)
      runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(5) | MRQ | RDS | A01, "lod_mem_wait");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b1, 1'b1, st(5) | MRQ | RDS | A01, "lod_mem_rdy");
    runCycle(OP_STR, 4'd0, 4'd0, 1'b0, 1'b1, st(6) | RFW | WBS | RDS | A01, "lod_wb");
    runCycle(OP_STR, 4'd0, 4'd0, 1'b0, 1'b1, st(2) | PCW, "str_fetch");

    // STR completes immediately and skips WB
    runCycle(OP_STR, 4'd0, 4'd0, 1'b0, 1'b1, st(3), "str_decode");
    runCycle(OP_STR, 4'd0, 4'd0, 1'b0, 1'b1, st(4) | RDS | A01, "str_exec");
    runCycle(OP_STR, 4'd0, 4'd0, 1'b1, 1'b1, st(5) | MRQ | MWE | RDS | A01, "str_mem");
    runCycle(OP_BRA, 4'd2, 4'd0, 1'b0, 1'b1, st(2) | PCW, "bra_fetch");

    // BRA taken (absolute)
    runCycle(OP_BRA, 4'd2, 4'd0, 1'b0, 1'b1, st(3), "bra_decode");
    runCycle(OP_NOOP, 4'd0, 4'd2, 1'b0, 1'b1, st(4) | A10 | PCS | PCW | BRS, "bra_taken");
    runCycle(OP_BRR, 4'd2, 4'd0, 1'b0, 1'b1, st(2) | PCW, "brr_fetch");

    // BRR not taken
    runCycle(OP_BRR, 4'd2, 4'd0, 1'b0, 1'b1, st(3), "brr_decode");
    runCycle(OP_NOOP, 4'd0, 4'd0, 1'b0, 1'b1, st(4) | A10, "brr_not_taken");
    runCycle(OP_BRR, 4'd3, 4'd0, 1'b0, 1'b1, st(2) | PCW, "brr2_fetch");

    // BRR taken (relative)
    runCycle(OP_BRR, 4'd3, 4'd0, 1'b0, 1'b1, st(3), "brr2_decode");
    runCycle(OP_NOOP, 4'd0, 4'd1, 1'b0, 1'b1, st(4) | A10 | PCS | PCW, "brr_taken");
    runCycle(OP_BNE, 4'd1, 4'd0, 1'b0, 1'b1, st(2) | PCW, "bne_fetch");

    // BNE taken when masked flags are clear
    runCycle(OP_BNE, 4'd1, 4'd0, 1'b0, 1'b1, st(3), "bne_decode");
    runCycle(OP_NOOP, 4'd0, 4'd4, 1'b0, 1'b1, st(4) | A10 | PCS | PCW | BRS, "bne_taken");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(2) | PCW, "tmo_fetch");

    // LOD timeout: 15 stalled MEM cycles then HALT with ERR
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(3), "tmo_decode");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(4) | RDS | A01, "tmo_exec");
    for (int i = 0; i < 15; i++)
      runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(5) | MRQ | RDS | A01, "tmo_mem");
    runCycle(OP_ALU, 4'd0, 4'd0, 1'b0, 1'b1, st(7) | HAL | ERB, "tmo_halt");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b1, 1'b1, st(7) | HAL | ERB, "halt_sticky");

    // Reset clears ERR; LOD with MEM_RDY on the 15th MEM cycle completes
    resetSequence(OP_LOD, 4'd0);
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(2) | PCW, "edge_fetch");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(3), "edge_decode");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(4) | RDS | A01, "edge_exec");
    for (int i = 0; i < 14; i++)
      runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(5) | MRQ | RDS | A01, "edge_mem");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b1, 1'b1, st(5) | MRQ | RDS | A01, "edge_mem15_rdy");
    runCycle(OP_BAD, 4'd0, 4'd0, 1'b0, 1'b1, st(6) | RFW | WBS | RDS | A01, "edge_wb");
    runCycle(OP_BAD, 4'd0, 4'd0, 1'b0, 1'b1, st(2) | PCW, "bad_fetch");

    // Undefined opcode traps
    runCycle(OP_BAD, 4'd0, 4'd0, 1'b0, 1'b1, st(3), "bad_decode");
    runCycle(OP_NOOP, 4'd0, 4'd0, 1'b0, 1'b1, st(7) | HAL | ERB, "bad_halt");

    // HLT halts without error
    resetSequence(OP_HLT, 4'd0);
    runCycle(OP_HLT, 4'd0, 4'd0, 1'b0, 1'b1, st(2) | PCW, "hlt_fetch");
    runCycle(OP_HLT, 4'd0, 4'd0, 1'b0, 1'b1, st(3), "hlt_decode");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(7) | HAL, "hlt_halt");

    // Stall during MEM, then asynchronous reset while the request is pending
    resetSequence(OP_LOD, 4'd0);
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b0, st(2), "stall_fetch");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(2) | PCW, "en_fetch");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(3), "en_decode");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(4) | RDS | A01, "en_exec");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(5) | MRQ | RDS | A01, "en_mem");
    for (int i = 0; i < 5; i++)
      runCycle(OP_LOD, 4'd0, 4'd0, 1'b1, 1'b0, st(5) | RDS | A01, "stall_mem");
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(5) | MRQ | RDS | A01, "resume_mem");
    rst_f = 1'b0;
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(0) | PCR, "async_reset_mem");
    rst_f = 1'b1;
    runCycle(OP_LOD, 4'd0, 4'd0, 1'b0, 1'b1, st(0) | PCR, "post_reset_start0");

    if (sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_leftover: observed %0d entries required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Parametrised multicycle CPU control FSM that decodes the instruction word and sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per opcode. It drives register-file, ALU, PC and data-memory controls.
- Adds over the previous controller: per-opcode stage skipping, load/store memory handshake with timeout, a sticky HALT state, illegal-opcode trapping and a global stall enable.
- Sits between the instruction register and the datapath (PC, register file, ALU, data memory).

Parameters:
OP_W, 4, opcode width; opcodes are NOOP=0, LOD=1, STR=2, BRA=4, BRR=5, BNE=6, ALU=8, HLT=all-ones, zero-extended to OP_W
MM_W, 4, addressing-mode/condition-mask field width; also the STAT width
IMM_MODE, 8, MM value selecting immediate operand for ALU ops
TMO_W, 4, memory-timeout counter width
MEM_TIMEOUT, 15, cycles in MEM without MEM_RDY before error trap; 0 disables the timeout

Ports:
CLK  in  1  clock, rising edge
RST_F  in  1  asynchronous active-low reset
EN  in  1  stall control; 0 freezes the FSM
OPCODE  in  OP_W  instruction opcode field
MM  in  MM_W  mode / condition-mask field
STAT  in  MM_W  ALU status flags
MEM_RDY  in  1  data memory done
RF_WE  out  1  register-file write enable
WB_SEL  out  1  0 = ALU result, 1 = memory data
RD_SEL  out  1  1 = immediate operand
ALU_OP  out  2  00 = reg op, 01 = immediate add/op, 10 = pass/branch
PC_SEL  out  1  1 = load branch target
BR_SEL  out  1  1 = absolute target, 0 = relative
PC_WRITE  out  1  PC update enable
PC_RST  out  1  PC reset
MEM_REQ  out  1  data memory request
MEM_WE  out  1  data memory write
HALTED  out  1  in HALT state
ERR  out  1  sticky error (illegal opcode or timeout)
STATE  out  3  present state, for debug

Behaviour:
- States and encoding: START0=0, START1=1, FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WB=6, HALT=7.
- Reset (RST_F=0, async): state START0, latched OPCODE/MM cleared, timeout counter 0, ERR 0. Outputs during reset: PC_RST=1, all others 0, STATE=0.
- START0 -> START1 -> FETCH. PC_RST=1 in START0/START1, 0 in every other state.
- OPCODE and MM are latched on the rising edge that leaves DECODE. EXECUTE/MEM/WB decode only the latched copies.
- All outputs are combinational from present state, latched fields and STAT. No output glitch requirement beyond single-cycle settle.
- FETCH: PC_WRITE=1, PC_SEL=0. Next state DECODE.
- DECODE: RD_SEL=1 if OPCODE=ALU and MM=IMM_MODE. Next state by opcode:
  - NOOP -> FETCH
  - HLT -> HALT
  - undefined opcode -> HALT with ERR set
  - all others -> EXECUTE
- ALU: EXECUTE -> WB.
  - ALU_OP=01 if MM=IMM_MODE, else 00, held through WB; RD_SEL held through WB.
  - WB: RF_WE=1, WB_SEL=0. WB -> FETCH.
- LOD/STR: EXECUTE computes the address with ALU_OP=01, RD_SEL=1, then -> MEM.
  - MEM: MEM_REQ=1; MEM_WE=1 for STR only. ALU_OP/RD_SEL held.
  - Stay in MEM until MEM_RDY=1.
  - On MEM_RDY: LOD -> WB (RF_WE=1, WB_SEL=1); STR -> FETCH.
- Branches: single EXECUTE cycle, ALU_OP=10, then -> FETCH.
  - BRA/BRR taken when (MM & STAT) != 0; BNE taken when (MM & STAT) == 0.
  - Taken: PC_SEL=1, PC_WRITE=1; BR_SEL=1 for BRA/BNE, 0 for BRR.
  - Not taken: PC_SEL=0, PC_WRITE=0.
  - STAT is sampled in EXECUTE only.
- Timeout counter: cleared on MEM entry; increments each MEM cycle with MEM_RDY=0, saturating.
  - When MEM_TIMEOUT != 0 and the count equals MEM_TIMEOUT with MEM_RDY still 0: -> HALT with ERR set.
  - MEM_RDY=1 on that same cycle wins: normal completion, no error.
- HALT: sticky until reset. HALTED=1, all write/request outputs 0, OPCODE ignored.
- EN=0:
  - State, latches and counter hold.
  - RF_WE, PC_WRITE, MEM_REQ and MEM_WE are forced to 0; other outputs reflect the held state.
  - The MEM timeout does not advance while EN=0.
- Reset asserted mid-instruction (including in MEM with a request pending): immediate return to START0; MEM_REQ drops asynchronously.
- ERR is cleared only by reset.

Test Plan:
- Reset release, then OPCODE=ALU, MM=0 -> STATE 0,1,2,3,4,6,2; RF_WE=1 only in WB; ALU_OP=00; PC_WRITE=1 in FETCH only.
- ALU with MM=8 -> RD_SEL=1 in DECODE/EXECUTE/WB, ALU_OP=01. NOOP -> FETCH->DECODE->FETCH with RF_WE never 1.
- LOD with MEM_RDY low 3 cycles, then high -> MEM_REQ high 4 cycles, MEM_WE=0, then WB with WB_SEL=1, RF_WE=1. STR -> MEM_WE=1, returns to FETCH, no RF_WE.
- BRA MM=4'b0010, STAT=4'b0010 -> PC_SEL=1, BR_SEL=1. BRR STAT=0 -> PC_SEL=0, PC_WRITE=0. BNE MM=4'b0001, STAT=4'b0100 -> taken, BR_SEL=1.
- LOD with MEM_RDY held 0, MEM_TIMEOUT=15 -> HALT after 15 MEM cycles, ERR=1, HALTED=1. Repeat with MEM_RDY=1 on cycle 15 -> no error. Opcode 3 -> HALT, ERR=1.
- EN=0 for 5 cycles during MEM, then RST_F pulsed low while in MEM -> state frozen and MEM_REQ=0 while EN=0; after reset STATE=0, PC_RST=1, ERR=0.
